// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment monitor: segment patterns,
// error codes, FSM states and the registered sample payload.
package seg7_pkg;

    localparam int unsigned SEG_W     = 7;
    localparam int unsigned AN_W      = 2;
    localparam int unsigned VAL_W     = 4;
    localparam int unsigned ERR_CNT_W = 8;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
    localparam logic [SEG_W-1:0] SEG_A     = 7'h08;
    localparam logic [SEG_W-1:0] SEG_B     = 7'h03;
    localparam logic [SEG_W-1:0] SEG_C     = 7'h46;
    localparam logic [SEG_W-1:0] SEG_D     = 7'h21;
    localparam logic [SEG_W-1:0] SEG_E     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_F     = 7'h0E;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    localparam logic [AN_W-1:0] AN_NONE = 2'b11;
    localparam logic [AN_W-1:0] AN_BOTH = 2'b00;
    localparam logic [AN_W-1:0] AN_DIG1 = 2'b01;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'b00,
        ERR_PATTERN    = 2'b01,
        ERR_CONTENTION = 2'b10
    } err_code_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_TRACK  = 2'b01,
        ST_LOCKED = 2'b10
    } state_e;

    typedef struct packed {
        logic [SEG_W-1:0] seg;
        logic [AN_W-1:0]  anode;
    } sample_t;

    // Blank segments or no digit selected: nothing is being displayed
    function automatic logic is_quiet(input sample_t s);
        return (s.seg == SEG_BLANK) || (s.anode == AN_NONE);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Inverse seven-segment decoder.
//   seg   : active-low segment pattern {g,f,e,d,c,b,a}
//   legal : pattern is one of the 16 hex glyphs
//   value : decoded hex value (0 when not legal)
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic             legal,
    output logic [VAL_W-1:0] value
);

    always_comb begin
        legal = 1'b1;
        value = '0;
        case (seg)
            SEG_0:   value = 4'h0;
            SEG_1:   value = 4'h1;
            SEG_2:   value = 4'h2;
            SEG_3:   value = 4'h3;
            SEG_4:   value = 4'h4;
            SEG_5:   value = 4'h5;
            SEG_6:   value = 4'h6;
            SEG_7:   value = 4'h7;
            SEG_8:   value = 4'h8;
            SEG_9:   value = 4'h9;
            SEG_A:   value = 4'hA;
            SEG_B:   value = 4'hB;
            SEG_C:   value = 4'hC;
            SEG_D:   value = 4'hD;
            SEG_E:   value = 4'hE;
            SEG_F:   value = 4'hF;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_monitor.sv
// Seven-segment display self-checker. Waits for a displayed pattern to be
// stable for STABLE_CYCLES samples, then reports the decoded digit or an
// error (illegal pattern / anode contention) with a one-cycle pulse.
//   clk, reset (sync, active-low)
//   seg[6:0], anode[1:0] : observed display nets (active-low)
//   digit_valid/digit_idx/digit_val : captured digit pulse
//   last_val0/last_val1             : latest value seen per digit
//   err_pulse/err_code/err_count    : error pulse, sticky type, saturating count
module seg7_monitor
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SEG_W-1:0]     seg,
    input  logic [AN_W-1:0]      anode,
    output logic                 digit_valid,
    output logic                 digit_idx,
    output logic [VAL_W-1:0]     digit_val,
    output logic [VAL_W-1:0]     last_val0,
    output logic [VAL_W-1:0]     last_val1,
    output logic                 err_pulse,
    output logic [1:0]           err_code,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

    state_e           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    sample_t          samp, cur_c;
    logic             quiet_c, same_c, fire_c;
    logic             legal_c;
    logic [VAL_W-1:0] dec_val_c;
    logic             rep_digit_c, rep_pat_c, rep_cont_c;

    always_comb begin
        cur_c.seg   = seg;
        cur_c.anode = anode;
    end

    assign quiet_c = is_quiet(cur_c);
    assign same_c  = (cur_c == samp);

    seg7_decode u_decode (
        .seg   (seg),
        .legal (legal_c),
        .value (dec_val_c)
    );

    // State, stability counter and previous-sample register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            samp.seg   <= SEG_BLANK;
            samp.anode <= AN_NONE;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            samp  <= cur_c;
        end
    end

    // Next-state: fire_c marks the edge taking the last required stable sample
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        fire_c  = 1'b0;
        if (quiet_c) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
        end else if (!same_c) begin
            state_n = ST_TRACK;
            cnt_n   = CNT_W'(1);
        end else begin
            case (state)
                ST_LOCKED: begin
                    state_n = ST_LOCKED;
                end
                ST_TRACK: begin
                    cnt_n = cnt + CNT_W'(1);
                    if (cnt_n == CNT_W'(STABLE_CYCLES)) begin
                        state_n = ST_LOCKED;
                        fire_c  = 1'b1;
                    end
                end
                default: begin
                    // Unreachable: IDLE always holds a quiet sample
                    state_n = ST_TRACK;
                    cnt_n   = CNT_W'(1);
                end
            endcase
        end
    end

    // Classify the report; fire_c implies non-quiet, so anode is never 2'b11
    always_comb begin
        rep_digit_c = 1'b0;
        rep_pat_c   = 1'b0;
        rep_cont_c  = 1'b0;
        if (fire_c) begin
            if (anode == AN_BOTH) begin
                rep_cont_c = 1'b1;
            end else if (!legal_c) begin
                rep_pat_c = 1'b1;
            end else begin
                rep_digit_c = 1'b1;
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            digit_valid <= 1'b0;
            digit_idx   <= 1'b0;
            digit_val   <= '0;
            last_val0   <= '0;
            last_val1   <= '0;
            err_pulse   <= 1'b0;
            err_code    <= ERR_NONE;
            err_count   <= '0;
        end else begin
            digit_valid <= rep_digit_c;
            err_pulse   <= rep_pat_c | rep_cont_c;
            if (rep_digit_c) begin
                digit_idx <= (anode == AN_DIG1);
                digit_val <= dec_val_c;
                if (anode == AN_DIG1) begin
                    last_val1 <= dec_val_c;
                end else begin
                    last_val0 <= dec_val_c;
                end
            end
            if (rep_pat_c) begin
                err_code <= ERR_PATTERN;
            end
            if (rep_cont_c) begin
                err_code <= ERR_CONTENTION;
            end
            if ((rep_pat_c || rep_cont_c) && (err_count != '1)) begin
                err_count <= err_count + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/seg7_monitor.md
Name: seg7_monitor

Overview:
- Hardware self-checker for the two-digit, time-multiplexed, active-low seven-segment display interface. It sits on the same seg/anode nets that the display driver produces.
- It waits for each displayed pattern to stay stable, then decodes it back to a hex digit. Each captured digit is reported with a one-cycle pulse.
- It flags illegal patterns and anode contention, and keeps a saturating error count. This closes the loop for on-board and simulation checking of the encoder.

Parameters:
- STABLE_CYCLES, 4, number of consecutive identical samples needed before a capture or error is reported; legal range 2..255.
- CNT_W, $clog2(STABLE_CYCLES+1), width of the stability counter; derived, not overridden.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-low reset.
- seg, input, 7, segment drive, active-low, bit order {g,f,e,d,c,b,a}.
- anode, input, 2, digit select, active-low; 2'b10 selects digit 0, 2'b01 selects digit 1.
- digit_valid, output, 1, one-cycle pulse when a digit is captured.
- digit_idx, output, 1, index of the captured digit; meaningful only when digit_valid is high.
- digit_val, output, 4, decoded hex value; meaningful only when digit_valid is high.
- last_val0, output, 4, most recent value captured on digit 0.
- last_val1, output, 4, most recent value captured on digit 1.
- err_pulse, output, 1, one-cycle pulse when an error is detected.
- err_code, output, 2, error type: 01 = illegal pattern, 10 = anode contention; holds its last value.
- err_count, output, 8, error counter, saturates at 255.

Behaviour:
- Reset (reset==0 at a clk edge): all outputs go to 0; the FSM goes to IDLE; the counter goes to 0; the sample register goes to {seg=7'h7F, anode=2'b11}.
- Reset takes priority over everything. Asserting it mid-tracking discards the partial count; no pulse follows.
- Legal patterns (active-low), values 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex).
- Blank (7'h7F) or anode==2'b11 is a "quiet" sample. Quiet samples are never captured and never counted as errors.
- Sampling: every edge registers {seg, anode}. A sample is "same" when it equals the previously registered sample; otherwise the count restarts at 1.
- FSM states:
  - IDLE: entered on a quiet sample.
  - TRACK: entered on a non-quiet sample that differs from the previous one. The count increments on each same sample.
  - LOCKED: entered once the count reaches STABLE_CYCLES. The FSM stays there while samples remain the same. Any change returns it to TRACK (count=1) or to IDLE if the new sample is quiet.
- On the edge that takes the STABLE_CYCLES-th consecutive identical non-quiet sample, exactly one of these happens (registered, visible in the next cycle):
  - Anode==2'b00 (contention): err_pulse=1, err_code=10, err_count+1.
  - Anode one-hot with an illegal seg: err_pulse=1, err_code=01, err_count+1.
  - Anode one-hot with a legal seg: digit_valid=1, digit_idx=(anode==2'b01), digit_val=decoded value, and the matching last_valN is updated.
- Latency: a pattern applied before edge 1 and held produces its pulse after edge STABLE_CYCLES.
- No re-report while LOCKED, however long the pattern is held. A change followed by a return to the same pattern is reported again.
- A change in anode alone (same seg) counts as a change.
- err_count saturates: at 255, further errors still pulse err_pulse but the count stays at 255.
- digit_valid and err_pulse are never high in the same cycle.

Decomposition:
- Package seg7_pkg holds the 16 segment-pattern constants, SEG_BLANK=7'h7F, the err_code enum (ERR_NONE, ERR_PATTERN, ERR_CONTENTION) and the FSM state enum.
- Combinational sub-module seg7_decode: seg[6:0] in; legal (1 bit) and value[3:0] out; a case statement over the package constants.

Test Plan:
- Hold reset=0 for 2 cycles with seg=7'h12, anode=2'b10 -> all outputs 0. Release and hold for 4 edges -> digit_valid=1 for exactly one cycle, digit_idx=0, digit_val=5, last_val0=5. Hold 10 more cycles -> no further pulse.
- Alternate seg=7'h12/anode=10 and seg=7'h0E/anode=01, each for 6 cycles -> pulses alternate (idx0, val 5) and (idx1, val F); last_val0=5, last_val1=F.
- Apply seg=7'h7F, then seg=7'h24 for only 3 cycles, then 7'h30 held -> no pulse for blank or the 3-cycle glitch; a single pulse with value 3.
- Hold seg=7'h55 with anode=10 -> err_pulse once, err_code=01, err_count=1. Then seg=7'h00 with anode=00 -> err_code=10, err_count=2.
- Repeat the illegal-pattern episode 260 times -> err_count stays at 255 and err_pulse still fires on each episode.
- Hold seg=7'h79 for 2 cycles, assert reset for 1 cycle, release and keep holding -> no pulse until 4 post-reset edges, then digit_val=1.
